viol_reset_responder: RTL

- Consumer end of the security-monitor reset path.
- Receives the individual per-monitor violation lines, one bit per monitor, before they are OR-ed together.
- Drives a stretched, sequenced CPU reset and confirms the core restarts at RESET_HANDLER.
- Keeps a sticky, software-readable violation-cause record on the openMSP430 peripheral bus, so attestation and authentication code can report why the last reset happened.

---
 rtl/viol_reset_responder_pkg.sv | 57 +++++
 rtl/viol_reset_responder_if.sv | 18 +
 rtl/viol_reset_responder_hold_timer.sv | 37 +++
 rtl/viol_reset_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/viol_reset_responder_pkg.sv
// Shared definitions for the violation reset responder: FSM states, violation
// line indices, CAUSE register field layout and the default register address.
package viol_reset_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_WAIT_PC = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    VIOL_XSTACK     = 3'd0,
    VIOL_AC         = 3'd1,
    VIOL_DMA_AC     = 3'd2,
    VIOL_DMA_DETECT = 3'd3,
    VIOL_DMA_XSTACK = 3'd4,
    VIOL_ATOMICITY  = 3'd5,
    VIOL_RATA       = 3'd6,
    VIOL_GAROTA     = 3'd7
  } viol_idx_e;

  localparam int CAUSE_W         = 8;
  localparam int CAUSE_BITS_LSB  = 0;
  localparam int CAUSE_FIRST_LSB = 8;
  localparam int CAUSE_FIRST_W   = 3;
  localparam int CAUSE_VALID_BIT = 15;

  localparam logic [13:0] CAUSE_ADDR_DEFAULT = 14'h0070;

  function automatic logic [CAUSE_FIRST_W-1:0] lowest_set(input logic [CAUSE_W-1:0] v);
    logic [CAUSE_FIRST_W-1:0] idx;
    idx = 3'd0;
    for (int i = CAUSE_W - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // FIRST is only meaningful while VALID is set, so it is hidden otherwise.
  function automatic logic [15:0] pack_cause(input logic [CAUSE_W-1:0]       cause,
                                             input logic [CAUSE_FIRST_W-1:0] first,
                                             input logic                     valid);
    logic [15:0] r;
    r = 16'h0000;
    r[CAUSE_BITS_LSB +: CAUSE_W] = cause;
    if (valid) begin
      r[CAUSE_FIRST_LSB +: CAUSE_FIRST_W] = first;
    end else begin
      r[CAUSE_FIRST_LSB +: CAUSE_FIRST_W] = 3'd0;
    end
    r[CAUSE_VALID_BIT] = valid;
    return r;
  endfunction

endpackage

// File: rtl/viol_reset_responder_if.sv
// openMSP430 peripheral bus slice used to read/clear the violation-cause record.
interface viol_reset_responder_if;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;

  modport master (
    output per_en, per_we, per_addr, per_din,
    input  per_dout
  );

  modport slave (
    input  per_en, per_we, per_addr, per_din,
    output per_dout
  );
endinterface

// File: rtl/viol_reset_responder_hold_timer.sv
// Loadable down-counter shared by the reset-hold and wait-for-PC phases.
// Decrement saturates at zero; load has priority over decrement.
module viol_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/viol_reset_responder.sv
// Security-monitor reset responder: stretched CPU reset, restart confirmation
// at RESET_HANDLER and a sticky cause register. Optional counter: VIOL_CNT_EN.
module viol_reset_responder
  import viol_reset_responder_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          RST_HOLD      = 8,
  parameter int          WAIT_TIMEOUT  = 16,
  parameter logic [13:0] CAUSE_ADDR    = CAUSE_ADDR_DEFAULT,
  parameter int          NVIOL         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NVIOL-1:0]     viol,
  input  logic [15:0]          pc,
  viol_reset_responder_if.slave per,
  output logic                 cpu_rst,
  output logic                 busy
);

  localparam int TMAX = (RST_HOLD > WAIT_TIMEOUT) ? RST_HOLD : WAIT_TIMEOUT;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(RST_HOLD - 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(WAIT_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic                     cpu_rst_q;
  logic                     busy_q;
  logic [CAUSE_W-1:0]       cause_q, cause_d;
  logic [CAUSE_FIRST_W-1:0] first_q, first_d;
  logic                     valid_q, valid_d;

  logic [CAUSE_W-1:0]       viol_s;
  logic                     viol_any_s;
  logic                     tmr_load_s;
  logic [TW-1:0]            tmr_val_s;
  logic                     tmr_dec_s;
  logic                     tmr_zero_s;
  logic                     capture_s;
  logic                     entry_s;
  logic                     cnt_inc_s;
  logic                     cause_wr_s;
  logic [CAUSE_W-1:0]       cause_set_s;
  logic [CAUSE_W-1:0]       cause_clr_s;

  assign viol_s     = CAUSE_W'(viol);
  assign viol_any_s = (viol_s != 8'h00);
  assign cause_wr_s = per.per_en && per.per_we[0] && (per.per_addr == CAUSE_ADDR);

  viol_hold_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .dec_i      (tmr_dec_s),
    .zero_o     (tmr_zero_s)
  );

  // Next-state and timer control; entry_s marks a fresh violation capture.
  always_comb begin
    state_d    = state_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = HOLD_LOAD;
    tmr_dec_s  = 1'b0;
    capture_s  = 1'b0;
    entry_s    = 1'b0;
    cnt_inc_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (viol_any_s) begin
          state_d    = ST_HOLD;
          tmr_load_s = 1'b1;
          capture_s  = 1'b1;
          entry_s    = 1'b1;
          cnt_inc_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        capture_s = 1'b1;
        if (viol_any_s) begin
          tmr_load_s = 1'b1;
        end else if (tmr_zero_s) begin
          state_d    = ST_WAIT_PC;
          tmr_load_s = 1'b1;
          tmr_val_s  = WAIT_LOAD;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_WAIT_PC: begin
        if (pc == RESET_HANDLER) begin
          state_d = ST_IDLE;
        end else if (viol_any_s) begin
          state_d    = ST_HOLD;
          tmr_load_s = 1'b1;
          capture_s  = 1'b1;
          entry_s    = 1'b1;
          cnt_inc_s  = 1'b1;
        end else if (tmr_zero_s) begin
          state_d    = ST_HOLD;
          tmr_load_s = 1'b1;
          cnt_inc_s  = 1'b1;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky cause update: W1C clear first, then new violations OR-ed in so set wins.
  always_comb begin
    cause_set_s = capture_s ? viol_s : 8'h00;
    cause_clr_s = cause_wr_s ? per.per_din[7:0] : 8'h00;
    cause_d     = (cause_q & ~cause_clr_s) | cause_set_s;
    first_d     = first_q;
    valid_d     = valid_q;
    if (entry_s && !valid_q) begin
      first_d = lowest_set(viol_s);
      valid_d = 1'b1;
    end else if (cause_wr_s && (cause_d == 8'h00)) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= (state_d == ST_HOLD);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q <= 8'h00;
      first_q <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      cause_q <= cause_d;
      first_q <= first_d;
      valid_q <= valid_d;
    end
  end

  assign cpu_rst = cpu_rst_q;
  assign busy    = busy_q;

`ifdef VIOL_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        cnt_wr_s;

  assign cnt_wr_s = per.per_en && (per.per_we != 2'b00) &&
                    (per.per_addr == (CAUSE_ADDR + 14'd1));

  // Saturating violation counter; a write clears it but a same-cycle entry still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_wr_s) begin
      cnt_d = cnt_inc_s ? 16'd1 : 16'd0;
    end else if (cnt_inc_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    per.per_dout = 16'h0000;
    if (per.per_en && (per.per_addr == CAUSE_ADDR)) begin
      per.per_dout = pack_cause(cause_q, first_q, valid_q);
    end else if (per.per_en && (per.per_addr == (CAUSE_ADDR + 14'd1))) begin
      per.per_dout = cnt_q;
    end else begin
      per.per_dout = 16'h0000;
    end
  end

  logic unused_s;
  assign unused_s = ^{per.per_din[15:8]};
`else
  always_comb begin
    per.per_dout = 16'h0000;
    if (per.per_en && (per.per_addr == CAUSE_ADDR)) begin
      per.per_dout = pack_cause(cause_q, first_q, valid_q);
    end else begin
      per.per_dout = 16'h0000;
    end
  end

  logic unused_s;
  assign unused_s = ^{per.per_din[15:8], per.per_we[1], cnt_inc_s};
`endif

endmodule
